// File: rtl/aos_softreg_endpoint_pkg.sv
// Shared types for the soft-register endpoint: shell request/response records
// and AOS F1 endpoint constants.
package ShellTypes;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

endpackage

package AOSF1Types;

  // Returned to the host when the application never answers an external read.
  localparam logic [63:0] SR_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_EXT_WAIT = 1'b1
  } ep_state_e;

endpackage

// File: rtl/aos_softreg_endpoint_fifo.sv
// Request buffer: synchronous FIFO of 2**LOG_DEPTH entries; q shows the head
// whenever empty is low, and rdreq pops it at the next edge.
module HullFIFO #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  input  logic             rdreq
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr;
  logic [LOG_DEPTH:0] rd_ptr;
  logic               do_wr;
  logic               do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                 (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
  assign do_wr = wrreq && !full;
  assign do_rd = rdreq && !empty;
  assign q     = mem[rd_ptr[LOG_DEPTH-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[LOG_DEPTH-1:0]] <= data;
  end

endmodule

// File: rtl/aos_softreg_endpoint.sv
// Soft-register endpoint: host writes land in control registers, reads return
// control/status values locally or are forwarded to the application with a timeout.
module aos_softreg_endpoint
  import ShellTypes::*;
  import AOSF1Types::*;
#(
  parameter int NUM_CTRL       = 4,
  parameter int NUM_STAT       = 4,
  parameter int TIMEOUT        = 256,
  parameter int FIFO_LOG_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  SoftRegReq                 sr_req,
  output SoftRegResp                sr_resp,
  output logic [NUM_CTRL-1:0][63:0] ctrl_regs,
  output logic [NUM_CTRL-1:0]       ctrl_wr_pulse,
  input  logic [NUM_STAT-1:0][63:0] stat_regs,
  output logic                      ext_rd_valid,
  output logic [31:0]               ext_rd_idx,
  input  logic                      ext_rd_ack,
  input  logic [63:0]               ext_rd_data,
  output logic                      err_overflow,
  output logic                      err_timeout,
  output ep_state_e                 dbg_state
);

  // Handshake: sr_req.valid is a single-cycle offer with no ready; the endpoint
  // buffers it or drops it (err_overflow). sr_resp has no backpressure.
  // ext_rd_valid is held until the cycle ext_rd_ack is sampled high.

  localparam int              CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]     LOCAL_END = 32'(NUM_CTRL + NUM_STAT);

  ep_state_e                   state, state_d;
  logic [CNT_W-1:0]            cnt, cnt_d;
  logic                        fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [$bits(SoftRegReq)-1:0] fifo_q;
  SoftRegReq                   head;
  logic [31:0]                 head_idx;
  SoftRegResp                  resp_d;
  logic                        ext_valid_d;
  logic [31:0]                 ext_idx_d;
  logic [NUM_CTRL-1:0]         ctrl_we;
  logic                        timeout_hit;
  logic                        unused_head_bits;

  assign fifo_wr          = sr_req.valid && !fifo_full;
  assign head             = SoftRegReq'(fifo_q);
  assign head_idx         = {3'b000, head.addr[31:3]};
  assign unused_head_bits = &{1'b0, head.valid, head.addr[63:32], head.addr[2:0]};
  assign dbg_state        = state;

  HullFIFO #(
    .WIDTH     ($bits(SoftRegReq)),
    .LOG_DEPTH (FIFO_LOG_DEPTH)
  ) u_req_fifo (
    .clock   (clk),
    .reset_n (rst_n),
    .wrreq   (fifo_wr),
    .data    (sr_req),
    .full    (fifo_full),
    .q       (fifo_q),
    .empty   (fifo_empty),
    .rdreq   (fifo_rd)
  );

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    fifo_rd     = 1'b0;
    resp_d      = '0;
    ext_valid_d = ext_rd_valid;
    ext_idx_d   = ext_rd_idx;
    ctrl_we     = '0;
    timeout_hit = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (head.is_write) begin
            for (int i = 0; i < NUM_CTRL; i++)
              if (head_idx == 32'(i)) ctrl_we[i] = 1'b1;
          end else if (head_idx < LOCAL_END) begin
            resp_d.valid = 1'b1;
            for (int i = 0; i < NUM_CTRL; i++)
              if (head_idx == 32'(i)) resp_d.data = ctrl_regs[i];
            for (int i = 0; i < NUM_STAT; i++)
              if (head_idx == 32'(NUM_CTRL + i)) resp_d.data = stat_regs[i];
          end else begin
            state_d     = ST_EXT_WAIT;
            cnt_d       = '0;
            ext_valid_d = 1'b1;
            ext_idx_d   = head_idx;
          end
        end
      end
      ST_EXT_WAIT: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (ext_rd_ack) begin
          resp_d.valid = 1'b1;
          resp_d.data  = ext_rd_data;
          ext_valid_d  = 1'b0;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          resp_d.valid = 1'b1;
          resp_d.data  = SR_TIMEOUT_DATA;
          timeout_hit  = 1'b1;
          ext_valid_d  = 1'b0;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      sr_resp       <= '0;
      ctrl_regs     <= '0;
      ctrl_wr_pulse <= '0;
      ext_rd_valid  <= 1'b0;
      ext_rd_idx    <= '0;
      err_overflow  <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      sr_resp       <= resp_d;
      ctrl_wr_pulse <= ctrl_we;
      ext_rd_valid  <= ext_valid_d;
      ext_rd_idx    <= ext_idx_d;
      for (int i = 0; i < NUM_CTRL; i++)
        if (ctrl_we[i]) ctrl_regs[i] <= head.data;
      if (sr_req.valid && fifo_full) err_overflow <= 1'b1;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/aos_softreg_endpoint.md
AOS_SOFTREG_ENDPOINT -- requirements
Module: aos_softreg_endpoint

Interface
REQ-001 SHALL have parameter NUM_CTRL, 4, number of host-writable control registers (index 0..NUM_CTRL-1).
REQ-002 SHALL have parameter NUM_STAT, 4, number of host-read-only status registers (index NUM_CTRL..NUM_CTRL+NUM_STAT-1).
REQ-003 SHALL have parameter TIMEOUT, 256, maximum cycles to wait for an external read response.
REQ-004 SHALL have parameter FIFO_LOG_DEPTH, 2, log2 of the request buffer depth.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n:
- clk  in  1  sole clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
REQ-006 SHALL have the remaining ports:
- sr_req  in  SoftRegReq  request from the route tree leaf; routing bits already masked
- sr_resp  out  SoftRegResp  response to the route tree leaf; no backpressure
- ctrl_regs  out  NUM_CTRL x 64  control register values
- ctrl_wr_pulse  out  NUM_CTRL  one-cycle strobe per control register on host write
- stat_regs  in  NUM_STAT x 64  status values sampled on read
- ext_rd_valid  out  1  external read request; held until ext_rd_ack
- ext_rd_idx  out  32  register index of the external read (addr[31:3])
- ext_rd_ack  in  1  app returns external read data this cycle
- ext_rd_data  in  64  external read data
- err_overflow  out  1  sticky; a request was dropped because the buffer was full
- err_timeout  out  1  sticky; an external read timed out

Function
REQ-007 SHALL compute the register index as sr_req.addr[31:3] and SHALL ignore addr[2:0].
REQ-008 SHALL enqueue every cycle with sr_req.valid=1 into the request FIFO, and SHALL drop the request and set err_overflow when the FIFO is full.
REQ-009 SHALL process the FIFO head only in state IDLE, at most one request per cycle.
REQ-010 Write, index < NUM_CTRL: SHALL update ctrl_regs[idx] to data on the next edge, pulse ctrl_wr_pulse[idx] for exactly that one cycle, and produce no response.
REQ-011 Write, index >= NUM_CTRL: SHALL be discarded with no response and no state change.
REQ-012 Read of a control or status register: SHALL assert sr_resp.valid for exactly one cycle, one cycle after dequeue (latency 1 from the head).
REQ-013 Read response data SHALL be ctrl_regs[idx] or the stat_regs value sampled on the dequeue cycle.
REQ-014 Read, index >= NUM_CTRL+NUM_STAT: SHALL dequeue, assert ext_rd_valid with ext_rd_idx, and enter state EXT_WAIT.
REQ-015 EXT_WAIT: SHALL increment a cycle counter from 0 each cycle.
REQ-016 EXT_WAIT with ext_rd_ack=1: SHALL respond with ext_rd_data on the next cycle, deassert ext_rd_valid, and return to IDLE.
REQ-017 EXT_WAIT with counter reaching TIMEOUT-1 and no ack: SHALL respond with 64'hFFFF_FFFF_FFFF_FFFF, set err_timeout, deassert ext_rd_valid, and return to IDLE.
REQ-018 SHALL treat ack on the timeout cycle as ack: data is returned and err_timeout stays unchanged.
REQ-019 SHALL ignore ext_rd_ack in IDLE.
REQ-020 SHALL continue enqueueing requests while in EXT_WAIT; requests are answered in arrival order.
REQ-021 SHALL drive sr_resp.valid=0 and sr_resp.data=0 on every cycle without a response.

Reset
REQ-022 Reset SHALL set ctrl_regs, ctrl_wr_pulse, ext_rd_valid, sr_resp, err_overflow, err_timeout and the counter to 0, set state to IDLE, and empty the FIFO.
REQ-023 Reset asserted in EXT_WAIT SHALL abandon the external read with no response after reset deassertion.

Structure
REQ-024 SoftRegReq and SoftRegResp SHALL come from ShellTypes; the timeout data constant SR_TIMEOUT_DATA SHALL live in AOSF1Types.
REQ-025 The request buffer SHALL be one HullFIFO instance of width $bits(SoftRegReq), with reset_n driven by rst_n.

Verification
REQ-026 Write idx 2 data 64'h1234 -> ctrl_regs[2]=64'h1234 and ctrl_wr_pulse[2] high one cycle; read idx 2 -> sr_resp 64'h1234 one cycle after dequeue.
REQ-027 stat_regs[1]=64'hABCD with NUM_CTRL=4, read idx 5 -> sr_resp.data 64'hABCD.
REQ-028 Read idx 20, ext_rd_ack with data 64'h55 after 10 cycles -> one response 64'h55; err_timeout=0.
REQ-029 Read idx 20, never acked, then read idx 0 -> 64'hFFFF_FFFF_FFFF_FFFF after TIMEOUT cycles, err_timeout=1, then ctrl_regs[0] value.
REQ-030 Read idx 20 unacked plus 5 back-to-back requests with depth 4 -> err_overflow=1 and 5th request dropped.
REQ-031 rst_n low mid-EXT_WAIT -> all outputs 0, no stale response after release.
